nn_inference_sequencer: RTL and testbench
=========================================

// Module: nn_inference_sequencer
// PURPOSE
//   Top-level scheduler for one inference pass: starts layer 1, then layer 2, then scans the
//   layer-2 logit buffer through its read port to find the winning class (argmax).
//   Sits between the host/pin interface and the two layer engines.
//   Owns every layer start line and the logit read address; the layers hold no sequencing logic.
// PARAMETERS
//   NUM_CLASSES     10    logits scanned (addresses 0..NUM_CLASSES-1)
//   LOGIT_W         6     signed logit width on l2_read_data
//   TIMEOUT_CYCLES  1024  per-layer watchdog limit (used only with NN_WATCHDOG_EN)
// PORTS
//   clk           in   1        single clock, rising edge
//   rst           in   1        asynchronous, active-high reset
//   start         in   1        level request; one inference per rising edge seen in IDLE
//   busy          out  1        high from the cycle after start accepted until DONE/ERR
//   done          out  1        high in DONE; held until start is low
//   class_out     out  4        index of max logit, valid while done=1
//   max_logit     out  LOGIT_W  signed value of winning logit, valid while done=1
//   err           out  1        watchdog fired (only with NN_WATCHDOG_EN; else tied 0)
//   l1_start      out  1        level start to layer 1
//   l1_done       in   1        layer 1 complete (level)
//   l2_start      out  1        level start to layer 2
//   l2_done       in   1        layer 2 complete (level)
//   l2_read_addr  out  4        logit read address to layer 2 (combinational read)
//   l2_read_data  in   LOGIT_W  signed logit at l2_read_addr, same cycle
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, err, l1_start, l2_start = 0; class_out=0; max_logit=0; l2_read_addr=0.
//   States: IDLE -> L1_RUN -> L1_REL -> L2_RUN -> L2_REL -> SCAN -> DONE -> IDLE; ERR only with watchdog.
//   - IDLE: start=1 -> L1_RUN; l1_start=1, busy=1 from the next cycle.
//   - L1_RUN: hold l1_start=1 until l1_done=1 is sampled; then l1_start=0, go L1_REL.
//   - L1_REL: wait for l1_done=0 (engine back to idle); then l2_start=1, go L2_RUN.
//     Prevents a stale done from being taken for the next stage.
//   - L2_RUN / L2_REL: same pattern as L1 using l2_start/l2_done.
//     Leaving L2_REL sets l2_read_addr=0, best_idx=0, best_val = most-negative LOGIT_W value.
//   - SCAN: one address per cycle, 0..NUM_CLASSES-1.
//     Each cycle: if $signed(l2_read_data) > best_val, then best := (addr, data).
//     Comparison is strict, so ties keep the lowest index.
//     Exit after addr NUM_CLASSES-1 is compared: exactly NUM_CLASSES cycles in SCAN.
//     l2_read_addr returns to 0 on exit and never exceeds NUM_CLASSES-1.
//   - DONE: class_out/max_logit registered from best_*; done=1, busy=0.
//     Stay until start=0, then IDLE with done=0 on the next cycle.
//     Outputs keep their value until the next scan completes.
//   Handshake rules
//     - start=1 outside IDLE is ignored.
//     - start held high continuously yields one inference only; a low->high is needed to rerun.
//     - l1_start and l2_start are never high together.
//     - l1_done/l2_done are ignored in states that do not wait on them.
//   Reset mid-operation: immediate return to reset values; start lines drop asynchronously.
//   Latency (ideal engines, done one cycle after start):
//     start -> done = 1 + L1(2) + L2(2) + NUM_CLASSES + 1 cycles.
// CONFIGURATION
//   NN_WATCHDOG_EN defined:
//     - Cycle counter cleared on entry to each *_RUN / *_REL state.
//     - Reaching TIMEOUT_CYCLES -> ERR: start lines=0, busy=0, err=1.
//     - ERR exits to IDLE only when start=0; err clears on the next accepted start.
//   Not defined: no counter, no ERR state, err tied to 0; an engine hang stalls the sequencer indefinitely.
// TESTING
//   1 logits {0,3,-2,7,1,7,-32,0,5,2}, ideal engines -> class_out=3, max_logit=7
//     (tie with idx5 resolved low), done at the computed latency.
//   2 all logits -32 -> class_out=0, max_logit=-32; all logits 31 -> class_out=0, max_logit=31.
//   3 start held high 200 cycles -> exactly one l1_start rise;
//     l1_done left high 3 extra cycles -> l2_start waits until it drops.
//   4 rst pulse mid-SCAN and mid-L2_RUN -> outputs at reset values within the reset cycle;
//     fresh start then completes normally.
//   5 NN_WATCHDOG_EN, TIMEOUT_CYCLES=16, l2_done never asserted
//     -> err=1 and l2_start=0 after 16 cycles in L2_RUN; start low then high -> err=0, new run.
//   6 start pulsed during busy -> ignored; no extra l1_start rise; result unchanged.

Source files
------------

// File: rtl/nn_inference_sequencer.sv
// Inference pass scheduler: layer 1, layer 2, then an argmax scan of the logits.
// Optional per-layer watchdog with ERR state: define NN_WATCHDOG_EN.
module nn_inference_sequencer #(
  parameter int NUM_CLASSES    = 10,
  parameter int LOGIT_W        = 6,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [3:0]         class_out,
  output logic [LOGIT_W-1:0] max_logit,
  output logic               err,
  output logic               l1_start,
  input  logic               l1_done,
  output logic               l2_start,
  input  logic               l2_done,
  output logic [3:0]         l2_read_addr,
  input  logic [LOGIT_W-1:0] l2_read_data
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_L1_RUN = 3'd1;
  localparam logic [2:0] S_L1_REL = 3'd2;
  localparam logic [2:0] S_L2_RUN = 3'd3;
  localparam logic [2:0] S_L2_REL = 3'd4;
  localparam logic [2:0] S_SCAN   = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;
`ifdef NN_WATCHDOG_EN
  localparam logic [2:0] S_ERR    = 3'd7;
`endif

  localparam logic [3:0] LAST_ADDR = 4'(NUM_CLASSES - 1);
  localparam logic signed [LOGIT_W-1:0] MOST_NEG =
    {1'b1, {(LOGIT_W-1){1'b0}}};

  logic [2:0]                state;
  logic [2:0]                state_n;
  logic [3:0]                best_idx;
  logic signed [LOGIT_W-1:0] best_val;
  logic signed [LOGIT_W-1:0] rd_val;
  logic                      better;
  logic [3:0]                next_idx;
  logic signed [LOGIT_W-1:0] next_val;
  logic                      scan_last;
  logic                      run_busy;

  // Strict compare: on a tie the earlier (lower) index is kept.
  always_comb begin
    rd_val    = $signed(l2_read_data);
    better    = rd_val > best_val;
    next_idx  = better ? l2_read_addr : best_idx;
    next_val  = better ? rd_val : best_val;
    scan_last = (l2_read_addr == LAST_ADDR);
  end

`ifdef NN_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt;
  logic          wd_active;
  logic          wd_fire;

  always_comb begin
    wd_active = (state == S_L1_RUN) || (state == S_L1_REL) ||
                (state == S_L2_RUN) || (state == S_L2_REL);
    wd_fire   = wd_active && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
  end
`endif

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (start)     state_n = S_L1_RUN;
      S_L1_RUN: if (l1_done)   state_n = S_L1_REL;
      S_L1_REL: if (!l1_done)  state_n = S_L2_RUN;
      S_L2_RUN: if (l2_done)   state_n = S_L2_REL;
      S_L2_REL: if (!l2_done)  state_n = S_SCAN;
      S_SCAN:   if (scan_last) state_n = S_DONE;
      S_DONE:   if (!start)    state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
`ifdef NN_WATCHDOG_EN
    if (state == S_ERR) begin
      state_n = start ? S_ERR : S_IDLE;
    end else if (wd_fire && (state_n == state)) begin
      state_n = S_ERR;
    end
`endif
  end

  always_comb begin
    run_busy = (state_n == S_L1_RUN) || (state_n == S_L1_REL) ||
               (state_n == S_L2_RUN) || (state_n == S_L2_REL) ||
               (state_n == S_SCAN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      l1_start     <= 1'b0;
      l2_start     <= 1'b0;
      l2_read_addr <= 4'd0;
      best_idx     <= 4'd0;
      best_val     <= MOST_NEG;
      class_out    <= 4'd0;
      max_logit    <= '0;
    end else begin
      state    <= state_n;
      busy     <= run_busy;
      done     <= (state_n == S_DONE);
      l1_start <= (state_n == S_L1_RUN);
      l2_start <= (state_n == S_L2_RUN);

      if ((state == S_SCAN) && (state_n == S_SCAN)) begin
        l2_read_addr <= l2_read_addr + 4'd1;
      end else begin
        l2_read_addr <= 4'd0;
      end

      if ((state == S_L2_REL) && (state_n == S_SCAN)) begin
        best_idx <= 4'd0;
        best_val <= MOST_NEG;
      end else if (state == S_SCAN) begin
        best_idx <= next_idx;
        best_val <= next_val;
      end

      if ((state == S_SCAN) && (state_n == S_DONE)) begin
        class_out <= next_idx;
        max_logit <= next_val;
      end
    end
  end

`ifdef NN_WATCHDOG_EN
  // Counter restarts on every state change so each phase gets a full budget.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt <= '0;
    end else if ((state_n != state) || !wd_active) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (state_n == S_ERR) begin
      err <= 1'b1;
    end else if ((state == S_IDLE) && (state_n == S_L1_RUN)) begin
      err <= 1'b0;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Bench for nn_inference_sequencer: behavioural layer engines plus a
// scoreboard of expected argmax results.
module tb_nn_inference_sequencer;

  localparam int NC = 10;
  localparam int LW = 6;
  localparam int LAT_IDEAL = 1 + 2 + 2 + NC + 1;

  typedef struct {
    logic [3:0]           cls;
    logic signed [LW-1:0] val;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic [3:0]    class_out;
  logic [LW-1:0] max_logit;
  logic          err;
  logic          l1_start;
  logic          l1_done;
  logic          l2_start;
  logic          l2_done;
  logic [3:0]    l2_read_addr;
  logic [LW-1:0] l2_read_data;

  logic signed [LW-1:0] logits [NC];
  exp_t sbq[$];

  int compared = 0;
  int mismatched = 0;

  // engine models: done one cycle after start, optionally held longer
  logic l1_q = 1'b0;
  logic l2_q = 1'b0;
  int   l1_hold = 0;
  int   l1_extra = 0;
  int   l2_extra = 0;
  bit   l2_hang = 1'b0;

  int   l1_rises = 0;
  int   overlap = 0;
  int   l2_early = 0;
  logic l1_prev = 1'b0;

  always #5 clk = ~clk;

  nn_inference_sequencer #(
    .NUM_CLASSES(NC),
    .LOGIT_W(LW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .busy(busy),
    .done(done),
    .class_out(class_out),
    .max_logit(max_logit),
    .err(err),
    .l1_start(l1_start),
    .l1_done(l1_done),
    .l2_start(l2_start),
    .l2_done(l2_done),
    .l2_read_addr(l2_read_addr),
    .l2_read_data(l2_read_data)
  );

  always @(posedge clk) begin
    l1_q <= l1_start;
    l2_q <= l2_start;
    if (l1_start) l1_extra <= l1_hold;
    else if (l1_extra > 0) l1_extra <= l1_extra - 1;
    l2_extra <= 0;
    l1_prev <= l1_start;
    if (l1_start && !l1_prev) l1_rises++;
    if (l1_start && l2_start) overlap++;
    if (l2_start && l1_done) l2_early++;
  end

  assign l1_done = (l1_q && l1_start) || (l1_extra > 0);
  assign l2_done = !l2_hang && ((l2_q && l2_start) || (l2_extra > 0));
  assign l2_read_data = (int'(l2_read_addr) < NC) ?
                        logits[int'(l2_read_addr)] : '0;

  function automatic exp_t model();
    exp_t e;
    e.cls = 4'd0;
    e.val = -6'sd32;
    for (int i = 0; i < NC; i++) begin
      if (logits[i] > e.val) begin
        e.cls = 4'(i);
        e.val = logits[i];
      end
    end
    return e;
  endfunction

  task automatic kick();
    sbq.push_back(model());
    @(negedge clk);
    start = 1'b1;
  endtask

  task automatic wait_done(input string name, input int exp_lat);
    int   lat;
    exp_t e;
    lat = 0;
    @(posedge clk);
    #1;
    while (done !== 1'b1 && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    compared++;
    if (done !== 1'b1) begin
      mismatched++;
      $display("FAIL %s_done: done=%b after %0d cycles, required 1",
               name, done, lat);
    end
    compared++;
    if (lat != exp_lat) begin
      mismatched++;
      $display("FAIL %s_latency: got %0d cycles, required %0d",
               name, lat, exp_lat);
    end
    compared++;
    if (sbq.size() == 0) begin
      mismatched++;
      $display("FAIL %s_scoreboard: got empty queue, required 1 entry", name);
    end else begin
      e = sbq.pop_front();
      if (class_out !== e.cls || max_logit !== e.val) begin
        mismatched++;
        $display("FAIL %s_result: got class %0d logit %0d, required %0d %0d",
                 name, class_out, $signed(max_logit), e.cls, e.val);
      end
    end
  endtask

  task automatic release_start(input string name);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    compared++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL %s_release: got done=%b busy=%b, required 0 0",
               name, done, busy);
    end
  endtask

  task automatic check_zero(input string name);
    logic [LW+15:0] v;
    v = {busy, done, err, l1_start, l2_start,
         class_out, max_logit, l2_read_addr};
    compared++;
    if (v !== '0) begin
      mismatched++;
      $display("FAIL %s: got outputs %h, required all 0", name, v);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sbq.delete();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_zero("reset_hold");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset_idle");
  endtask

  task automatic test_basic();
    logits = '{0, 3, -2, 7, 1, 7, -32, 0, 5, 2};
    kick();
    wait_done("basic", LAT_IDEAL);
    release_start("basic");
    logits = '{-5, -9, 2, 2, -1, 30, -31, 29, 30, 0};
    kick();
    wait_done("mixed", LAT_IDEAL);
    release_start("mixed");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NC; i++) logits[i] = -6'sd32;
    kick();
    wait_done("all_min", LAT_IDEAL);
    release_start("all_min");
    for (int i = 0; i < NC; i++) logits[i] = 6'sd31;
    kick();
    wait_done("all_max", LAT_IDEAL);
    release_start("all_max");
    for (int i = 0; i < NC; i++) logits[i] = (i == NC - 1) ? 6'sd4 : -6'sd3;
    kick();
    wait_done("last_wins", LAT_IDEAL);
    release_start("last_wins");
  endtask

  task automatic test_start_held();
    int r0;
    logits = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
    r0 = l1_rises;
    kick();
    wait_done("held", LAT_IDEAL);
    repeat (200 - LAT_IDEAL) @(negedge clk);
    compared++;
    if (l1_rises - r0 != 1 || done !== 1'b1) begin
      mismatched++;
      $display("FAIL held_once: got %0d rises done=%b, required 1 1",
               l1_rises - r0, done);
    end
    release_start("held");
    l1_hold = 3;
    logits = '{4, -1, 9, 9, 0, 0, 0, 0, 0, 0};
    kick();
    wait_done("l1_stale", LAT_IDEAL + 3);
    release_start("l1_stale");
    l1_hold = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    logits = '{3, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    kick();
    n = 0;
    while (l2_read_addr != 4'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero("rst_mid_scan");
    repeat (2) @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    sbq.delete();
    kick();
    n = 0;
    while (l2_start !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    #2 rst = 1'b1;
    #1 check_zero("rst_mid_l2");
    repeat (2) @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    sbq.delete();
    repeat (3) @(negedge clk);
    logits = '{-2, 8, -4, 8, 6, 0, 1, 1, 1, 1};
    kick();
    wait_done("after_rst", LAT_IDEAL);
    release_start("after_rst");
  endtask

  task automatic test_ignore_start();
    int r0;
    logits = '{0, 0, 0, 0, 0, 0, 0, 0, 12, 0};
    r0 = l1_rises;
    kick();
    fork
      begin
        repeat (4) @(negedge clk);
        start = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk) start = 1'b1;
      end
    join_none
    wait_done("ignore", LAT_IDEAL);
    compared++;
    if (l1_rises - r0 != 1) begin
      mismatched++;
      $display("FAIL ignore_rises: got %0d, required 1", l1_rises - r0);
    end
    release_start("ignore");
  endtask

  task automatic test_watchdog();
    int n;
    logits = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    l2_hang = 1'b1;
    @(negedge clk);
    start = 1'b1;
`ifdef NN_WATCHDOG_EN
    n = 0;
    while (l2_start !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    n = 0;
    while (err !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    compared++;
    if (err !== 1'b1 || n != 16 || l2_start !== 1'b0 || busy !== 1'b0) begin
      mismatched++;
      $display("FAIL wd_fire: got err=%b n=%0d l2s=%b busy=%b, req 1 16 0 0",
               err, n, l2_start, busy);
    end
    @(negedge clk);
    start = 1'b0;
    l2_hang = 1'b0;
    repeat (3) @(negedge clk);
    compared++;
    if (err !== 1'b1) begin
      mismatched++;
      $display("FAIL wd_hold: got err=%b, required 1", err);
    end
    kick();
    wait_done("wd_rerun", LAT_IDEAL);
    compared++;
    if (err !== 1'b0) begin
      mismatched++;
      $display("FAIL wd_clear: got err=%b, required 0", err);
    end
    release_start("wd_rerun");
`else
    repeat (60) @(negedge clk);
    n = 0;
    compared++;
    if (err !== 1'b0 || l2_start !== 1'b1 || busy !== 1'b1) begin
      mismatched++;
      $display("FAIL stall: got err=%b l2s=%b busy=%b n=%0d, required 0 1 1",
               err, l2_start, busy, n);
    end
    start = 1'b0;
    l2_hang = 1'b0;
    do_reset();
    kick();
    wait_done("stall_rerun", LAT_IDEAL);
    release_start("stall_rerun");
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_held();
    test_reset_mid();
    test_ignore_start();
    test_watchdog();
    compared++;
    if (overlap != 0 || l2_early != 0) begin
      mismatched++;
      $display("FAIL handshake: got overlap=%0d early=%0d, required 0 0",
               overlap, l2_early);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
